pio_input_shift: RTL and testbench

//  Input shift register (ISR) of one PIO state machine: the receive-side counterpart of the pin driver.

---
 rtl/pio_pkg.sv | 17 +
 rtl/pio_pin_sync.sv | 28 ++
 rtl/pio_input_shift.sv | 124 ++++++++++++
 tb/tb_pio_input_shift.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/pio_pkg.sv
// Shared widths, command encodings and count decode for the PIO input shift path.
package pio_pkg;

    localparam int unsigned ISR_W = 32;
    localparam int unsigned CNT_W = 6;

    localparam logic OP_IN   = 1'b0;
    localparam logic OP_PUSH = 1'b1;

    localparam logic [CNT_W-1:0] FULL_COUNT = CNT_W'(ISR_W);

    // Bit counts and thresholds encode a full word as 0; out-of-range values clamp to a full word.
    function automatic logic [CNT_W-1:0] decodeCount(input logic [CNT_W-1:0] raw);
        return ((raw == '0) || (raw > FULL_COUNT)) ? FULL_COUNT : raw;
    endfunction

endpackage

// File: rtl/pio_pin_sync.sv
// Per-bit two-flop synchronizer for asynchronous pin inputs.
// Only built when PIO_INSYNC_EN is defined.
`ifdef PIO_INSYNC_EN
module pio_pin_sync
    import pio_pkg::*;
#(
    parameter int unsigned W = ISR_W
) (
    input  logic         clock,
    input  logic         reset,
    input  logic [W-1:0] pinsAsync,
    output logic [W-1:0] pinsSync
);

    logic [W-1:0] meta;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            meta     <= '0;
            pinsSync <= '0;
        end else begin
            meta     <= pinsAsync;
            pinsSync <= meta;
        end
    end

endmodule
`endif

// File: rtl/pio_input_shift.sv
// PIO input shift register: shifts pin or register data into the ISR and pushes words to the RX slot.
// Define PIO_INSYNC_EN to pass pins_in through a two-flop synchronizer.
module pio_input_shift
    import pio_pkg::*;
(
    input  logic             clock,
    input  logic             reset,
    input  logic [ISR_W-1:0] pins_in,
    input  logic [4:0]       cfg_inBase,
    input  logic             cfg_shiftRight,
    input  logic             cfg_autoPush,
    input  logic [CNT_W-1:0] cfg_pushThresh,
    input  logic             cfg_clear,
    input  logic             cmd_valid,
    input  logic             cmd_op,
    input  logic             cmd_srcPins,
    input  logic [ISR_W-1:0] cmd_data,
    input  logic [CNT_W-1:0] cmd_bitCount,
    input  logic             cmd_block,
    input  logic             cmd_ifFull,
    output logic             cmd_ready,
    output logic [ISR_W-1:0] rx_data,
    output logic             rx_valid,
    input  logic             rx_ready,
    output logic [CNT_W-1:0] isr_count,
    output logic             rx_overflow
);

    logic [ISR_W-1:0] pinSrc;

`ifdef PIO_INSYNC_EN
    pio_pin_sync #(.W(ISR_W)) u_pinSync (
        .clock     (clock),
        .reset     (reset),
        .pinsAsync (pins_in),
        .pinsSync  (pinSrc)
    );
`else
    assign pinSrc = pins_in;
`endif

    logic [ISR_W-1:0] isr, isrNext, rxDataNext;
    logic [CNT_W-1:0] countNext;
    logic             rxValidNext, overflowNext;

    logic [CNT_W-1:0] n, thresh, newCount;
    logic [CNT_W:0]   countSum;
    logic [ISR_W-1:0] rotated, mask, src, shifted;
    logic             slotFree;

    // Operand selection: pins rotated so cfg_inBase lands on bit 0, masked to n bits.
    assign n        = decodeCount(cmd_bitCount);
    assign thresh   = decodeCount(cfg_pushThresh);
    assign rotated  = ISR_W'({pinSrc, pinSrc} >> cfg_inBase);
    assign mask     = (n == FULL_COUNT) ? '1 : ((ISR_W'(1) << n) - ISR_W'(1));
    assign src      = (cmd_srcPins ? rotated : cmd_data) & mask;
    assign shifted  = cfg_shiftRight ? ((isr >> n) | (src << (FULL_COUNT - n)))
                                     : ((isr << n) | src);
    assign countSum = {1'b0, isr_count} + {1'b0, n};
    assign newCount = (countSum > (CNT_W+1)'(ISR_W)) ? FULL_COUNT : countSum[CNT_W-1:0];
    assign slotFree = !rx_valid || rx_ready;

    always_comb begin
        isrNext      = isr;
        countNext    = isr_count;
        rxDataNext   = rx_data;
        rxValidNext  = rx_valid && !rx_ready;
        overflowNext = 1'b0;
        cmd_ready    = 1'b1;

        if (cfg_clear) begin
            isrNext   = '0;
            countNext = '0;
            cmd_ready = 1'b0;
        end else if (cmd_valid && (cmd_op == OP_IN)) begin
            if (cfg_autoPush && (newCount >= thresh)) begin
                if (slotFree) begin
                    rxDataNext  = shifted;
                    rxValidNext = 1'b1;
                    isrNext     = '0;
                    countNext   = '0;
                end else begin
                    cmd_ready = 1'b0;
                end
            end else begin
                isrNext   = shifted;
                countNext = newCount;
            end
        end else if (cmd_valid && (cmd_op == OP_PUSH)) begin
            // A conditional push below threshold is accepted without effect.
            if (!(cmd_ifFull && (isr_count < thresh))) begin
                if (slotFree) begin
                    rxDataNext  = isr;
                    rxValidNext = 1'b1;
                    isrNext     = '0;
                    countNext   = '0;
                end else if (cmd_block) begin
                    cmd_ready = 1'b0;
                end else begin
                    overflowNext = 1'b1;
                    isrNext      = '0;
                    countNext    = '0;
                end
            end
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            isr         <= '0;
            isr_count   <= '0;
            rx_data     <= '0;
            rx_valid    <= 1'b0;
            rx_overflow <= 1'b0;
        end else begin
            isr         <= isrNext;
            isr_count   <= countNext;
            rx_data     <= rxDataNext;
            rx_valid    <= rxValidNext;
            rx_overflow <= overflowNext;
        end
    end

endmodule

// File: tb/tb_pio_input_shift.sv
// Self-checking bench for pio_input_shift: directed scenarios plus random commands against a word-level model.
module tb_pio_input_shift;

    logic        clock = 1'b0;
    logic        reset;
    logic [31:0] pins_in;
    logic [4:0]  cfg_inBase;
    logic        cfg_shiftRight, cfg_autoPush, cfg_clear;
    logic [5:0]  cfg_pushThresh;
    logic        cmd_valid, cmd_op, cmd_srcPins, cmd_block, cmd_ifFull;
    logic [31:0] cmd_data;
    logic [5:0]  cmd_bitCount;
    logic        cmd_ready;
    logic [31:0] rx_data;
    logic        rx_valid, rx_ready, rx_overflow;
    logic [5:0]  isr_count;

    int nChecks = 0;
    int nPass   = 0;

    // Reference model state
    logic [31:0] mIsr, mRxData;
    int          mCount;
    bit          mRxValid, mOv;

    pio_input_shift dut (
        .clock          (clock),
        .reset          (reset),
        .pins_in        (pins_in),
        .cfg_inBase     (cfg_inBase),
        .cfg_shiftRight (cfg_shiftRight),
        .cfg_autoPush   (cfg_autoPush),
        .cfg_pushThresh (cfg_pushThresh),
        .cfg_clear      (cfg_clear),
        .cmd_valid      (cmd_valid),
        .cmd_op         (cmd_op),
        .cmd_srcPins    (cmd_srcPins),
        .cmd_data       (cmd_data),
        .cmd_bitCount   (cmd_bitCount),
        .cmd_block      (cmd_block),
        .cmd_ifFull     (cmd_ifFull),
        .cmd_ready      (cmd_ready),
        .rx_data        (rx_data),
        .rx_valid       (rx_valid),
        .rx_ready       (rx_ready),
        .isr_count      (isr_count),
        .rx_overflow    (rx_overflow)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nChecks++;
        assert (obs === exp) nPass++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    task automatic modelReset();
        mIsr = '0; mRxData = '0; mCount = 0; mRxValid = 0; mOv = 0;
    endtask

    task automatic checkOutputs(input string tag);
        chk({tag, ".rx_data"},     rx_data,            mRxData);
        chk({tag, ".rx_valid"},    32'(rx_valid),      32'(mRxValid));
        chk({tag, ".isr_count"},   32'(isr_count),     32'(mCount));
        chk({tag, ".rx_overflow"}, 32'(rx_overflow),   32'(mOv));
    endtask

    // One clock: predict from current inputs, check cmd_ready mid-cycle, advance, check registers.
    task automatic tick(input string tag);
        int n, thr, cnt;
        longint unsigned s, pw, res;
        logic [31:0] srcSel, nIsr, nRxData;
        int nCount;
        bit nRxValid, nOv, expReady, free;

        n   = (cmd_bitCount == 0 || cmd_bitCount > 32) ? 32 : int'(cmd_bitCount);
        thr = (cfg_pushThresh == 0 || cfg_pushThresh > 32) ? 32 : int'(cfg_pushThresh);
        free = !mRxValid || rx_ready;
        nRxValid = mRxValid && !rx_ready;
        nRxData = mRxData; nIsr = mIsr; nCount = mCount; nOv = 0; expReady = 1;

        if (cmd_srcPins) begin
            for (int i = 0; i < 32; i++) srcSel[i] = pins_in[(i + int'(cfg_inBase)) % 32];
        end else begin
            srcSel = cmd_data;
        end
        pw  = 64'd1 << n;
        s   = longint'(srcSel) % pw;
        if (cfg_shiftRight) res = longint'(mIsr) / pw + s * (64'd1 << (32 - n));
        else                res = longint'(mIsr) * pw + s;
        res = res % (64'd1 << 32);
        cnt = (mCount + n > 32) ? 32 : mCount + n;

        if (cfg_clear) begin
            nIsr = '0; nCount = 0; expReady = 0;
        end else if (cmd_valid && cmd_op == 1'b0) begin
            if (cfg_autoPush && cnt >= thr) begin
                if (free) begin
                    nRxData = 32'(res); nRxValid = 1; nIsr = '0; nCount = 0;
                end else begin
                    expReady = 0;
                end
            end else begin
                nIsr = 32'(res); nCount = cnt;
            end
        end else if (cmd_valid) begin
            if (!(cmd_ifFull && mCount < thr)) begin
                if (free) begin
                    nRxData = mIsr; nRxValid = 1; nIsr = '0; nCount = 0;
                end else if (cmd_block) begin
                    expReady = 0;
                end else begin
                    nOv = 1; nIsr = '0; nCount = 0;
                end
            end
        end

        @(negedge clock);
        chk({tag, ".cmd_ready"}, 32'(cmd_ready), 32'(expReady));
        @(posedge clock);
        #1;
        mIsr = nIsr; mCount = nCount; mRxData = nRxData; mRxValid = nRxValid; mOv = nOv;
        checkOutputs(tag);
    endtask

    task automatic idle();
        cmd_valid = 0; cfg_clear = 0;
    endtask

    task automatic setIn(input logic [31:0] d, input logic [5:0] cnt, input bit pins);
        cmd_valid = 1; cmd_op = 1'b0; cmd_data = d; cmd_bitCount = cnt; cmd_srcPins = pins;
    endtask

    task automatic setPush(input bit blk, input bit ifFull);
        cmd_valid = 1; cmd_op = 1'b1; cmd_block = blk; cmd_ifFull = ifFull; cmd_srcPins = 0;
    endtask

    initial begin
        reset = 0; pins_in = '0; cfg_inBase = '0; cfg_shiftRight = 0; cfg_autoPush = 0;
        cfg_pushThresh = '0; cfg_clear = 0; cmd_valid = 0; cmd_op = 0; cmd_srcPins = 0;
        cmd_data = '0; cmd_bitCount = '0; cmd_block = 0; cmd_ifFull = 0; rx_ready = 0;
        modelReset();

        @(negedge clock);
        checkOutputs("reset");
        chk("reset.cmd_ready", 32'(cmd_ready), 32'd1);
        reset = 1;
        @(posedge clock); #1;

        // Left shift, no autopush
        setIn(32'hA5, 6'd8, 0); tick("t1.in0");
        setIn(32'h3C, 6'd8, 0); tick("t1.in1");
        chk("t1.count16", 32'(isr_count), 32'd16);
        setPush(0, 0); tick("t1.push");
        chk("t1.isr_word", rx_data, 32'h0000A53C);
        idle(); rx_ready = 1; tick("t1.drain");

        // Right shift, autopush at full word
        cfg_shiftRight = 1; cfg_autoPush = 1; cfg_pushThresh = 6'd0; rx_ready = 0;
        setIn(32'h11, 6'd8, 0); tick("t2.in0");
        setIn(32'h22, 6'd8, 0); tick("t2.in1");
        setIn(32'h33, 6'd8, 0); tick("t2.in2");
        setIn(32'h44, 6'd8, 0); tick("t2.in3");
        chk("t2.rx_word", rx_data, 32'h44332211);
        chk("t2.count0", 32'(isr_count), 32'd0);

        // Autopush stalls while slot busy, accepted once the FIFO drains in the same cycle
        cfg_pushThresh = 6'd8;
        setIn(32'h66, 6'd8, 0); tick("t3.stall");
        chk("t3.rx_held", rx_data, 32'h44332211);
        rx_ready = 1; tick("t3.accept");
        chk("t3.rx_new", rx_data, 32'h66000000);
        rx_ready = 0;

        // Non-blocking push into a busy slot drops data; conditional push below threshold is a no-op
        cfg_autoPush = 0; cfg_shiftRight = 0;
        setIn(32'hAB, 6'd8, 0); tick("t4.in");
        setPush(0, 0); tick("t4.overflow");
        chk("t4.ovf", 32'(rx_overflow), 32'd1);
        chk("t4.rx_keep", rx_data, 32'h66000000);
        idle(); tick("t4.ovf_end");
        setIn(32'h9, 6'd4, 0); tick("t4.in4");
        setPush(0, 1); tick("t4.ifFull");
        chk("t4.count4", 32'(isr_count), 32'd4);

        // Rotated pin source
        cfg_clear = 1; cmd_valid = 0; tick("t5.clear");
        pins_in = 32'h80000001; cfg_inBase = 5'd31;
        idle(); repeat (3) tick("t5.settle");
        setIn(32'h0, 6'd2, 1); tick("t5.inpins");
        setPush(0, 0); rx_ready = 1; tick("t5.push");
        chk("t5.src", rx_data, 32'h3);

        // Random commands
        for (int it = 0; it < 400; it++) begin
            if (it % 25 == 0) begin
                pins_in = $urandom; cfg_inBase = 5'($urandom);
                idle(); repeat (3) tick("rnd.settle");
            end
            cfg_shiftRight = 1'($urandom);
            cfg_autoPush   = 1'($urandom);
            cfg_pushThresh = 6'($urandom_range(0, 32));
            cfg_clear      = ($urandom % 20 == 0);
            cmd_valid      = ($urandom % 4 != 0);
            cmd_op         = 1'($urandom);
            cmd_srcPins    = 1'($urandom);
            cmd_data       = $urandom;
            cmd_bitCount   = 6'($urandom_range(0, 32));
            cmd_block      = 1'($urandom);
            cmd_ifFull     = 1'($urandom);
            rx_ready       = ($urandom % 3 == 0);
            tick("rnd");
        end

        // Asynchronous reset mid-operation
        idle(); rx_ready = 0; cfg_autoPush = 0; cfg_shiftRight = 0;
        setIn(32'h1, 6'd16, 0); tick("t6.fill");
        setPush(0, 0); tick("t6.push");
        setIn(32'hFFF, 6'd12, 0); tick("t6.in12");
        chk("t6.pre_count", 32'(isr_count), 32'd12);
        chk("t6.pre_valid", 32'(rx_valid), 32'd1);
        idle();
        reset = 0;
        #1;
        modelReset();
        checkOutputs("t6.async");
        #2 reset = 1;
        @(posedge clock); #1;
        setPush(0, 0); tick("t6.isr_cleared");

        $display("%0d/%0d checks passed", nPass, nChecks);
        $finish;
    end

endmodule
